pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Sequencer for the front of the lapido pipeline. It decides cycle by cycle whether IF and ID advance, hold, or are flushed. It drives the `stall_pipeline` input of the decode stage and the PC-hold and flush controls of the fetch stage. Stall requests come from load-use hazards, taken branches, jumps and data-memory wait states. It also keeps saturating performance counters for stall and flush cycles.

## Interface
- `FLUSH_CYCLES`, default 2: bubble cycles inserted after a taken branch (legal range 1-7).
- `CNT_WIDTH`, default 32: width of the performance counters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_uses_rs` in 1: the ID instruction reads rs.
- `id_uses_rt` in 1: the ID instruction reads rt.
- `ex_is_load` in 1: the instruction in EX is a load.
- `ex_rd` in 5: destination register of the EX instruction.
- `branch_taken` in 1: pulse from MEM; a pc-relative branch resolved taken.
- `is_jump` in 1: the ID instruction is an unconditional jump (j/jr).
- `mem_busy` in 1: data memory is not ready this cycle.
- `pc_hold` out 1: IF keeps its PC and instruction.
- `stall_pipeline` out 1: ID emits a bubble.
- `flush_if` out 1: IF discards its fetched instruction.
- `state` out 2: current FSM state, for debug.
- `stall_cnt` out CNT_WIDTH: cycles spent in LOAD_STALL or MEM_WAIT.
- `flush_cnt` out CNT_WIDTH: cycles spent in FLUSH.

## Operation
- FSM states: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
- A load-use hazard exists when `ex_is_load` is high and `ex_rd` is not 0. In addition, either `id_uses_rs` is high and `id_rs`==`ex_rd`, or `id_uses_rt` is high and `id_rt`==`ex_rd`.
- Next-state priority, evaluated every cycle in every state: `rst` > `branch_taken` > `mem_busy` > load-use > jump/none.
- `branch_taken` goes to FLUSH and loads the flush counter with FLUSH_CYCLES-1. This holds in any state, including MEM_WAIT and FLUSH; a branch during FLUSH reloads the counter.
- `mem_busy` high goes to MEM_WAIT. MEM_WAIT stays while `mem_busy` is high. When `mem_busy` drops, the next state is decided by the priority list.
- A load-use hazard goes to LOAD_STALL for exactly one cycle. LOAD_STALL always exits: to RUN, or to a higher-priority state. The hazard cannot persist, because the load has then left EX.
- FLUSH decrements its counter each cycle. It leaves when the counter is 0 and no new `branch_taken` is present.
- A jump in RUN causes no state change. `flush_if` is asserted combinationally for that cycle only, discarding the sequential fetch.
- Outputs (Moore, from the state register, except the jump term):
  - RUN: all 0, except `flush_if`=`is_jump`.
  - LOAD_STALL: `pc_hold`=1, `stall_pipeline`=1.
  - FLUSH: `stall_pipeline`=1, `flush_if`=1, `pc_hold`=0.
  - MEM_WAIT: `pc_hold`=1, `stall_pipeline`=1.
- Counters increment by 1 in each cycle spent in the matching state. They saturate at all-ones and never wrap. They are cleared only by `rst`.

## Timing
- Hazard inputs are sampled at a rising edge. The response appears on the outputs in the following cycle, which aligns with the ID stage's registered `stall_pipeline` input.
- Latency: load-use stall is 1 cycle. Branch flush is FLUSH_CYCLES cycles. MEM_WAIT lasts for the number of cycles `mem_busy` was high as sampled.
- Reset: on a rising edge with `rst`=1, the state goes to RUN and the flush counter and both perf counters go to 0.
  - With `rst` held, `pc_hold`=0, `stall_pipeline`=0, `flush_if`=0, `state`=0, `stall_cnt`=0 and `flush_cnt`=0 from the first edge on.
  - Reset in the middle of FLUSH or MEM_WAIT abandons the sequence with no residual bubbles.
- Simultaneous `branch_taken` and `mem_busy`: the next state is FLUSH; `mem_busy` is re-evaluated when FLUSH exits.
- Simultaneous load-use and `is_jump` in RUN: LOAD_STALL wins. `flush_if` still follows `is_jump` in that cycle, because that term is combinational.
- Simultaneous `branch_taken` and load-use: the next state is FLUSH, and the hazard is discarded with the flushed instruction.

## Test plan
- Load-use hazard: `ex_is_load`=1, `ex_rd`=5, `id_rs`=5, `id_uses_rs`=1.
  - Next cycle: `state`=1, `pc_hold`=1, `stall_pipeline`=1.
  - The cycle after: RUN with all outputs 0, and `stall_cnt`=1.
  - Same stimulus with `ex_rd`=0 gives no stall.
- Branch flush: `branch_taken` pulse for 1 cycle with FLUSH_CYCLES=2.
  - Exactly 2 cycles of `flush_if`=1 and `stall_pipeline`=1 with `pc_hold`=0, then RUN.
  - `flush_cnt`=2.
  - A second pulse in the 2nd FLUSH cycle extends FLUSH to 4 cycles in total.
- Memory wait: `mem_busy` high for 3 cycles.
  - 3 cycles of MEM_WAIT with `pc_hold`=1, then RUN; `stall_cnt`=3.
  - A `branch_taken` pulse in the 2nd cycle moves to FLUSH on the next edge.
- Jump: `is_jump`=1 in RUN gives `flush_if`=1 in the same cycle and no state change.
- Reset mid-operation: assert `rst` in the 1st FLUSH cycle.
  - Next edge: `state`=0, all outputs 0, counters 0, and no further flush cycles.
- Counter saturation: with CNT_WIDTH=4, hold `mem_busy` for 20 cycles.
  - `stall_cnt` stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Front-end sequencer for the lapido pipeline: decides each cycle whether IF/ID
// advance, hold or flush, and keeps saturating stall/flush cycle counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_rs, id_rt             source register fields of the ID instruction
//   id_uses_rs, id_uses_rt   ID instruction actually reads rs / rt
//   ex_is_load, ex_rd        EX instruction is a load / its destination
//   branch_taken             taken-branch pulse from MEM
//   is_jump                  ID instruction is an unconditional jump
//   mem_busy                 data memory not ready this cycle
//   pc_hold                  IF keeps PC and instruction
//   stall_pipeline           ID emits a bubble
//   flush_if                 IF discards its fetched instruction
//   state                    current FSM state (debug)
//   stall_cnt, flush_cnt     saturating perf counters
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_is_load,
    input  logic [4:0]           ex_rd,
    input  logic                 branch_taken,
    input  logic                 is_jump,
    input  logic                 mem_busy,
    output logic                 pc_hold,
    output logic                 stall_pipeline,
    output logic                 flush_if,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int unsigned FCNT_W = 3;
    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              load_use;

    // Load-use hazard: EX load writes a register the ID instruction reads.
    always_comb begin
        load_use = ex_is_load && (ex_rd != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) ||
                    (id_uses_rt && (id_rt == ex_rd)));
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            fcnt_q    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (((state_q == LOAD_STALL) || (state_q == MEM_WAIT)) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if ((state_q == FLUSH) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
        end
    end

    // Next state and outputs. An unfinished FLUSH outranks mem_busy and
    // load-use; those are re-evaluated once the flush drains.
    always_comb begin
        state_d        = RUN;
        fcnt_d         = fcnt_q;
        pc_hold        = 1'b0;
        stall_pipeline = 1'b0;
        flush_if       = 1'b0;

        if (branch_taken) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
        end else if ((state_q == FLUSH) && (fcnt_q != '0)) begin
            state_d = FLUSH;
            fcnt_d  = fcnt_q - FCNT_W'(1);
        end else if (mem_busy) begin
            state_d = MEM_WAIT;
        end else if (load_use && (state_q != LOAD_STALL)) begin
            // LOAD_STALL lasts one cycle; the load has left EX afterwards.
            state_d = LOAD_STALL;
        end else begin
            state_d = RUN;
        end

        case (state_q)
            RUN: begin
                flush_if = is_jump;
            end
            LOAD_STALL, MEM_WAIT: begin
                pc_hold        = 1'b1;
                stall_pipeline = 1'b1;
            end
            FLUSH: begin
                stall_pipeline = 1'b1;
                flush_if       = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_is_load;
    logic        branch_taken, is_jump, mem_busy;
    logic        pc_hold, stall_pipeline, flush_if;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc_hold, s_stall_pipeline, s_flush_if;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .is_jump(is_jump), .mem_busy(mem_busy), .pc_hold(pc_hold),
        .stall_pipeline(stall_pipeline), .flush_if(flush_if), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .is_jump(is_jump), .mem_busy(mem_busy), .pc_hold(s_pc_hold),
        .stall_pipeline(s_stall_pipeline), .flush_if(s_flush_if), .state(s_state),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic [1:0] st,
                               input logic ph, input logic sp, input logic fi);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".pc_hold"}, 32'(pc_hold), 32'(ph));
        check({tag, ".stall"}, 32'(stall_pipeline), 32'(sp));
        check({tag, ".flush_if"}, 32'(flush_if), 32'(fi));
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; ex_is_load = 0;
        branch_taken = 0; is_jump = 0; mem_busy = 0;
    endtask

    task automatic set_load_use_rs();
        ex_is_load = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick(); tick();
        expect_outs("reset", 2'd0, 0, 0, 0);
        check("reset.stall_cnt", stall_cnt, 0);
        check("reset.flush_cnt", flush_cnt, 0);
        rst = 0;

        // Load-use on rs
        set_load_use_rs();
        tick();
        expect_outs("lu", 2'd1, 1, 1, 0);
        clear_inputs();
        tick();
        expect_outs("lu_after", 2'd0, 0, 0, 0);
        check("lu.stall_cnt", stall_cnt, 1);

        // ex_rd = 0 never hazards
        set_load_use_rs(); ex_rd = 5'd0; id_rs = 5'd0;
        tick();
        expect_outs("lu_r0", 2'd0, 0, 0, 0);
        clear_inputs();

        // Load-use on rt held two edges: LOAD_STALL still exits after one
        ex_is_load = 1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1;
        tick();
        check("lu_rt.state", 32'(state), 1);
        tick();
        check("lu_rt.exit", 32'(state), 0);
        clear_inputs();
        check("lu_rt.stall_cnt", stall_cnt, 2);

        // Branch flush, FLUSH_CYCLES=2
        branch_taken = 1;
        tick();
        branch_taken = 0;
        expect_outs("br1", 2'd2, 0, 1, 1);
        tick();
        expect_outs("br2", 2'd2, 0, 1, 1);
        tick();
        expect_outs("br_done", 2'd0, 0, 0, 0);
        check("br.flush_cnt", flush_cnt, 2);

        // Second pulse in FLUSH cycle 2 extends to 4 cycles
        branch_taken = 1;
        tick(); branch_taken = 0;
        tick(); branch_taken = 1;
        tick(); branch_taken = 0;
        check("brx3.state", 32'(state), 2);
        tick();
        check("brx4.state", 32'(state), 2);
        tick();
        check("brx_done.state", 32'(state), 0);
        check("brx.flush_cnt", flush_cnt, 6);

        // Memory wait, 3 cycles
        mem_busy = 1;
        tick();
        expect_outs("mw1", 2'd3, 1, 1, 0);
        tick(); tick();
        check("mw3.state", 32'(state), 3);
        mem_busy = 0;
        tick();
        expect_outs("mw_done", 2'd0, 0, 0, 0);
        check("mw.stall_cnt", stall_cnt, 5);

        // Branch during MEM_WAIT cycle 2
        mem_busy = 1;
        tick(); tick();
        branch_taken = 1;
        tick();
        branch_taken = 0; mem_busy = 0;
        check("mwbr.state", 32'(state), 2);
        tick(); tick();
        check("mwbr_done.state", 32'(state), 0);
        check("mwbr.stall_cnt", stall_cnt, 7);
        check("mwbr.flush_cnt", flush_cnt, 8);

        // Simultaneous branch and mem_busy: FLUSH first, then MEM_WAIT
        branch_taken = 1; mem_busy = 1;
        tick(); branch_taken = 0;
        check("brmw1.state", 32'(state), 2);
        tick();
        check("brmw2.state", 32'(state), 2);
        tick();
        check("brmw3.state", 32'(state), 3);
        mem_busy = 0;
        tick();
        check("brmw_done.state", 32'(state), 0);

        // Jump: combinational flush_if, no state change
        is_jump = 1;
        #1;
        expect_outs("jmp", 2'd0, 0, 0, 1);
        tick();
        check("jmp_next.state", 32'(state), 0);
        is_jump = 0;
        #1;
        check("jmp_off.flush_if", 32'(flush_if), 0);

        // Load-use together with jump: LOAD_STALL wins, flush_if follows jump
        set_load_use_rs(); is_jump = 1;
        #1;
        check("lujmp.flush_if", 32'(flush_if), 1);
        tick();
        clear_inputs();
        expect_outs("lujmp_stall", 2'd1, 1, 1, 0);
        tick();
        check("lujmp_done.state", 32'(state), 0);

        // Branch together with load-use: hazard discarded
        set_load_use_rs(); branch_taken = 1;
        tick();
        clear_inputs();
        check("brlu.state", 32'(state), 2);
        tick(); tick();
        check("brlu_done.state", 32'(state), 0);
        check("brlu.stall_cnt", stall_cnt, 9);
        check("brlu.flush_cnt", flush_cnt, 12);

        // Reset in FLUSH cycle 1
        branch_taken = 1;
        tick();
        branch_taken = 0; rst = 1;
        tick();
        rst = 0;
        expect_outs("rst_mid", 2'd0, 0, 0, 0);
        check("rst_mid.stall_cnt", stall_cnt, 0);
        check("rst_mid.flush_cnt", flush_cnt, 0);
        check("rst_mid.small_stall", 32'(s_stall_cnt), 0);
        tick();
        expect_outs("rst_after", 2'd0, 0, 0, 0);
        check("rst_after.flush_cnt", flush_cnt, 0);

        // Saturation: 20 MEM_WAIT cycles, 4-bit counter stops at 15
        mem_busy = 1;
        for (int i = 0; i < 20; i++) tick();
        mem_busy = 0;
        tick();
        check("sat.state", 32'(s_state), 0);
        check("sat.small_stall", 32'(s_stall_cnt), 15);
        check("sat.wide_stall", stall_cnt, 20);
        tick();
        check("sat.small_hold", 32'(s_stall_cnt), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
